// File: rtl/bitcomposer_pkg.sv
// Shared constants and types for the speaker pattern sequencer.
// Voice and step geometry, sequencer states, step-advance helper.
package bitcomposer_pkg;

  localparam int NUM_VOICES = 4;
  localparam int NUM_STEPS  = 16;
  localparam int STEP_W     = $clog2(NUM_STEPS);
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int PAT_BITS   = NUM_VOICES * NUM_STEPS;

  localparam logic [VOICE_W-1:0] VOICE_A = 2'd0;
  localparam logic [VOICE_W-1:0] VOICE_C = 2'd1;
  localparam logic [VOICE_W-1:0] VOICE_D = 2'd2;
  localparam logic [VOICE_W-1:0] VOICE_F = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  // Past the loop end (including after a shrink) we restart at 0.
  function automatic logic [STEP_W-1:0] next_step(
    input logic [STEP_W-1:0] idx,
    input logic [STEP_W-1:0] last
  );
    return (idx >= last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_gate_timer.sv
// Gate-length timer shared by all voices.
// CYCLES=0 gives legato: active from load until clear.
module gate_timer
  import bitcomposer_pkg::*;
#(
  parameter int CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  output logic active_o
);

  localparam int CW =
    (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (clear_i) begin
      cnt_d  = '0;
      hold_d = 1'b0;
    end else if (load_i) begin
      cnt_d  = CW'(CYCLES);
      hold_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign active_o = (CYCLES == 0) ? hold_q
                                  : (cnt_q != '0);

endmodule

// File: rtl/pattern_sequencer.sv
// Four-voice step sequencer: pattern store, play FSM,
// per-voice gates and LED view of the edited voice row.
module pattern_sequencer
  import bitcomposer_pkg::*;
#(
  parameter int GATE_CYCLES = 5_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  step_tick,
  input  logic                  play_toggle,
  input  logic                  stop,
  input  logic [STEP_W-1:0]     loop_len,
  input  logic [VOICE_W-1:0]    edit_voice,
  input  logic [STEP_W-1:0]     edit_step,
  input  logic                  edit_val,
  input  logic                  edit_wr,
  output logic [STEP_W-1:0]     step_idx,
  output logic                  step_pulse,
  output logic [NUM_VOICES-1:0] voice_gate,
  output logic                  playing,
  output logic [NUM_STEPS-1:0]  led_pattern
);

  seq_state_t              state_q, state_d;
  logic [STEP_W-1:0]       idx_q, idx_d;
  logic                    pulse_q;
  logic [PAT_BITS-1:0]     pat_q, pat_d;
  logic [NUM_VOICES-1:0]   gbits_q, gbits_d;
  logic [NUM_VOICES-1:0]   fire_col;
  logic                    fire;
  logic                    kill;
  logic                    gate_on;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fire    = 1'b0;
    kill    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
      kill    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (play_toggle) begin
          state_d = PLAY;
          idx_d   = '0;
          fire    = 1'b1;
        end
        PLAY: if (play_toggle) begin
          state_d = PAUSE;
          kill    = 1'b1;
        end else if (step_tick) begin
          idx_d = next_step(idx_q, loop_len);
          fire  = 1'b1;
        end
        PAUSE: if (play_toggle) begin
          state_d = PLAY;
          fire    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          kill    = 1'b1;
        end
      endcase
    end
  end

  // Column is taken from the pre-write pattern so a same-edge edit
  // only shows up on the next fire of that step.
  always_comb begin
    fire_col = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      fire_col[v] = pat_q[{VOICE_W'(v), idx_d}];
    end
  end

  always_comb begin
    gbits_d = gbits_q;
    if (kill) begin
      gbits_d = '0;
    end else if (fire) begin
      gbits_d = fire_col;
    end
  end

  always_comb begin
    pat_d = pat_q;
    if (edit_wr) begin
      pat_d[{edit_voice, edit_step}] = edit_val;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      pat_q   <= '0;
      gbits_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= fire;
      pat_q   <= pat_d;
      gbits_q <= gbits_d;
    end
  end

  gate_timer #(
    .CYCLES (GATE_CYCLES)
  ) u_gate (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .load_i   (fire),
    .clear_i  (kill),
    .active_o (gate_on)
  );

  logic [NUM_STEPS-1:0] led_row;
  logic [NUM_STEPS-1:0] led_mark;

  always_comb begin
    led_row  = pat_q[{edit_voice, {STEP_W{1'b0}}} +: NUM_STEPS];
    led_mark = '0;
    led_mark[idx_q] = (state_q == PLAY);
  end

  assign step_idx    = idx_q;
  assign step_pulse  = pulse_q;
  assign voice_gate  = gbits_q & {NUM_VOICES{gate_on}};
  assign playing     = (state_q == PLAY);
  assign led_pattern = led_row ^ led_mark;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed table, corner sequences,
// random traffic against a timeline-based reference model.
module tb_pattern_sequencer;

  localparam int GC = 8;

  logic        clk = 1'b0;
  logic        resetn, step_tick, play_toggle, stop;
  logic [3:0]  loop_len, edit_step;
  logic [1:0]  edit_voice;
  logic        edit_val, edit_wr;

  logic [3:0]  step_idx, step_idx0;
  logic        step_pulse, step_pulse0;
  logic [3:0]  voice_gate, voice_gate0;
  logic        playing, playing0;
  logic [15:0] led_pattern, led_pattern0;

  always #5 clk = ~clk;

  pattern_sequencer #(.GATE_CYCLES(GC)) dut (
    .CLOCK_50(clk), .resetn(resetn), .step_tick(step_tick),
    .play_toggle(play_toggle), .stop(stop), .loop_len(loop_len),
    .edit_voice(edit_voice), .edit_step(edit_step),
    .edit_val(edit_val), .edit_wr(edit_wr),
    .step_idx(step_idx), .step_pulse(step_pulse),
    .voice_gate(voice_gate), .playing(playing),
    .led_pattern(led_pattern)
  );

  pattern_sequencer #(.GATE_CYCLES(0)) dut0 (
    .CLOCK_50(clk), .resetn(resetn), .step_tick(step_tick),
    .play_toggle(play_toggle), .stop(stop), .loop_len(loop_len),
    .edit_voice(edit_voice), .edit_step(edit_step),
    .edit_val(edit_val), .edit_wr(edit_wr),
    .step_idx(step_idx0), .step_pulse(step_pulse0),
    .voice_gate(voice_gate0), .playing(playing0),
    .led_pattern(led_pattern0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: mode, position, pattern grid, and the time of the
  // last fire; a gate is lit for GC cycles after a fire (forever if 0).
  int  m_mode;
  int  m_idx;
  bit  m_pulse;
  bit  m_pat [4][16];
  bit  m_col [4];
  bit  m_live;
  int  m_fire_t;
  int  now_t = 0;

  function automatic logic [3:0] exp_gate(input bit legato);
    logic [3:0] g = '0;
    bit lit = m_live && (legato || (now_t - m_fire_t) < GC);
    for (int v = 0; v < 4; v++) g[v] = lit && m_col[v];
    return g;
  endfunction

  function automatic logic [15:0] exp_led();
    logic [15:0] r = '0;
    for (int s = 0; s < 16; s++) r[s] = m_pat[edit_voice][s];
    if (m_mode == 1) r[m_idx] = ~r[m_idx];
    return r;
  endfunction

  task automatic model_edge();
    bit fire = 0;
    now_t++;
    if (!resetn) begin
      m_mode = 0; m_idx = 0; m_pulse = 0; m_live = 0;
      foreach (m_pat[v, s]) m_pat[v][s] = 0;
      foreach (m_col[v]) m_col[v] = 0;
      return;
    end
    if (stop) begin
      m_mode = 0; m_idx = 0; m_live = 0;
    end else if (m_mode == 0 && play_toggle) begin
      m_mode = 1; m_idx = 0; fire = 1;
    end else if (m_mode == 1 && play_toggle) begin
      m_mode = 2; m_live = 0;
    end else if (m_mode == 1 && step_tick) begin
      m_idx = (m_idx >= int'(loop_len)) ? 0 : (m_idx + 1) % 16;
      fire = 1;
    end else if (m_mode == 2 && play_toggle) begin
      m_mode = 1; fire = 1;
    end
    m_pulse = fire;
    if (fire) begin
      for (int v = 0; v < 4; v++) m_col[v] = m_pat[v][m_idx];
      m_live = 1;
      m_fire_t = now_t;
    end
    if (edit_wr) m_pat[edit_voice][edit_step] = edit_val;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    model_edge();
    chk("m_idx",   32'(step_idx),    32'(m_idx));
    chk("m_pulse", 32'(step_pulse),  32'(m_pulse));
    chk("m_gate",  32'(voice_gate),  32'(exp_gate(0)));
    chk("m_gate0", 32'(voice_gate0), 32'(exp_gate(1)));
    chk("m_play",  32'(playing),     32'(m_mode == 1));
    chk("m_led",   32'(led_pattern), 32'(exp_led()));
    step_tick = 0; play_toggle = 0; stop = 0; edit_wr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int v, input int s, input bit val);
    edit_wr = 1; edit_voice = 2'(v);
    edit_step = 4'(s); edit_val = val;
  endtask

  typedef struct {
    bit play, tick, wr;
    logic [1:0] v; logic [3:0] s; bit val;
    logic [3:0] e_idx; bit e_pulse; logic [3:0] e_gate;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit p, bit t, bit w, int v, int s,
                              bit val, int ei, bit ep, int eg);
    vec_t r;
    r.play = p; r.tick = t; r.wr = w;
    r.v = 2'(v); r.s = 4'(s); r.val = val;
    r.e_idx = 4'(ei); r.e_pulse = ep; r.e_gate = 4'(eg);
    return r;
  endfunction

  int seq3[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    resetn = 0; step_tick = 0; play_toggle = 0; stop = 0;
    loop_len = 4'd15; edit_voice = 0; edit_step = 0;
    edit_val = 0; edit_wr = 0;
    m_mode = 0; m_idx = 0; m_pulse = 0; m_live = 0; m_fire_t = 0;
    foreach (m_pat[v, s]) m_pat[v][s] = 0;
    foreach (m_col[v]) m_col[v] = 0;
    idle(2);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_play", 32'(playing), 0);
    resetn = 1;

    // Voice A on steps 0 and 2, then play through steps 0..2.
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 1));
    foreach (tbl[i]) begin
      play_toggle = tbl[i].play; step_tick = tbl[i].tick;
      edit_wr = tbl[i].wr; edit_voice = tbl[i].v;
      edit_step = tbl[i].s; edit_val = tbl[i].val;
      cyc();
      chk($sformatf("tbl%0d_idx", i), 32'(step_idx), 32'(tbl[i].e_idx));
      chk($sformatf("tbl%0d_pulse", i), 32'(step_pulse),
          32'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d_gate", i), 32'(voice_gate),
          32'(tbl[i].e_gate));
    end

    // Short loop, then shrink the loop while sitting past its end.
    stop = 1; cyc();
    loop_len = 4'd3; play_toggle = 1; cyc();
    chk("loop_start", 32'(step_idx), 0);
    for (int i = 0; i < 8; i++) begin
      step_tick = 1; cyc();
      chk($sformatf("loop_%0d", i), 32'(step_idx), 32'(seq3[i]));
    end
    step_tick = 1; cyc(); step_tick = 1; cyc(); step_tick = 1; cyc();
    chk("loop_at3", 32'(step_idx), 3);
    loop_len = 4'd1; step_tick = 1; cyc();
    chk("loop_shrink", 32'(step_idx), 0);

    // Pause at step 5, ticks ignored, resume re-fires step 5.
    loop_len = 4'd15; stop = 1; cyc();
    wr(3, 5, 1); cyc();
    play_toggle = 1; cyc();
    for (int i = 0; i < 5; i++) begin step_tick = 1; cyc(); end
    chk("p5_gate", 32'(voice_gate), 4'b1000);
    play_toggle = 1; cyc();
    chk("pause_play", 32'(playing), 0);
    chk("pause_gate", 32'(voice_gate), 0);
    step_tick = 1; cyc();
    chk("pause_idx", 32'(step_idx), 5);
    chk("pause_pulse", 32'(step_pulse), 0);
    play_toggle = 1; cyc();
    chk("resume_idx", 32'(step_idx), 5);
    chk("resume_pulse", 32'(step_pulse), 1);
    chk("resume_gate", 32'(voice_gate), 4'b1000);

    // Edit the cell that fires on the same edge.
    stop = 1; cyc();
    play_toggle = 1; cyc();
    for (int i = 0; i < 3; i++) begin step_tick = 1; cyc(); end
    step_tick = 1; wr(1, 4, 1); cyc();
    chk("edit_same_idx", 32'(step_idx), 4);
    chk("edit_same_gate", 32'(voice_gate), 0);
    loop_len = 4'd4; step_tick = 1; cyc();
    chk("edit_wrap", 32'(step_idx), 0);
    for (int i = 0; i < 4; i++) begin step_tick = 1; cyc(); end
    chk("edit_next_gate", 32'(voice_gate), 4'b0010);

    // stop beats a coincident tick; legato holds the gate.
    stop = 1; step_tick = 1; cyc();
    chk("stop_play", 32'(playing), 0);
    chk("stop_idx", 32'(step_idx), 0);
    chk("stop_pulse", 32'(step_pulse), 0);
    play_toggle = 1; cyc();
    idle(15);
    chk("short_gate", 32'(voice_gate), 0);
    chk("legato_gate", 32'(voice_gate0), 4'b0001);
    step_tick = 1; cyc();
    chk("legato_next", 32'(voice_gate0), 0);

    // Reset in the middle of playback.
    step_tick = 1; cyc();
    chk("pre_rst_play", 32'(playing), 1);
    resetn = 0; cyc();
    chk("midrst_idx", 32'(step_idx), 0);
    chk("midrst_pulse", 32'(step_pulse), 0);
    chk("midrst_gate", 32'(voice_gate | voice_gate0), 0);
    chk("midrst_play", 32'(playing), 0);
    resetn = 1;
    for (int v = 0; v < 4; v++) begin
      edit_voice = 2'(v); #1;
      chk($sformatf("midrst_led%0d", v), 32'(led_pattern), 0);
    end

    // Random traffic, tempo tick every 20 cycles.
    for (int t = 0; t < 1500; t++) begin
      step_tick   = (t % 20 == 0);
      play_toggle = ($urandom_range(39) == 0);
      stop        = ($urandom_range(149) == 0);
      edit_wr     = ($urandom_range(3) == 0);
      edit_voice  = 2'($urandom_range(3));
      edit_step   = 4'($urandom_range(15));
      edit_val    = 1'($urandom_range(1));
      if ($urandom_range(99) == 0) loop_len = 4'($urandom_range(15));
      resetn = ($urandom_range(399) != 0);
      if (t == 10) play_toggle = 1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
